pipeline_reg_exe_mem_hs: RTL

Execute-to-Memory pipeline register with valid/ready flow control, synchronous flush and optional 2-entry skid buffer. It sits between the EX stage (ALU, store-data mux, dest-reg select) and the MEM stage (data memory, load path). Unlike the fixed-width plain EX/MEM register, it supports MEM-stage backpressure (multi-cycle memory), squashes bubbles on flush, and keeps saturating stall/bubble performance counters.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_skid_buf.sv | 105 ++++++++++
 rtl/pipeline_reg_exe_mem_hs.sv | 98 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the EX/MEM handshake pipeline register: occupancy states
// and the packed control bundle carried alongside the datapath payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    localparam int CTRL_W = 3;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic MemWrite;
    } ctrl_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register stage: 2-entry skid buffer with registered
// in_ready (SKID=1) or a single entry with combinational in_ready (SKID=0).
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 8,
    parameter bit SKID      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    generate
        if (SKID) begin : g_skid
            state_t                 state_q;
            logic [PAYLOAD_W-1:0]   main_q;
            logic [PAYLOAD_W-1:0]   skid_q;
            logic                   in_ready_q;
            logic                   accept;
            logic                   fire;

            assign accept      = in_valid_i & in_ready_q;
            assign fire        = (state_q != ST_EMPTY) & out_ready_i;
            assign in_ready_o  = in_ready_q;
            assign out_valid_o = (state_q != ST_EMPTY);
            assign out_data_o  = main_q;

            // in_ready is updated alongside the state so it is 0 exactly in ST_SKID.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    state_q    <= ST_EMPTY;
                    main_q     <= '0;
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else if (flush_i) begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (accept) begin
                                state_q <= ST_FULL;
                                main_q  <= in_data_i;
                            end
                        end
                        ST_FULL: begin
                            if (accept && fire) begin
                                main_q <= in_data_i;
                            end else if (accept) begin
                                state_q    <= ST_SKID;
                                skid_q     <= in_data_i;
                                in_ready_q <= 1'b0;
                            end else if (fire) begin
                                state_q <= ST_EMPTY;
                            end
                        end
                        ST_SKID: begin
                            if (fire) begin
                                state_q    <= ST_FULL;
                                main_q     <= skid_q;
                                in_ready_q <= 1'b1;
                            end
                        end
                        default: begin
                            state_q    <= ST_EMPTY;
                            in_ready_q <= 1'b1;
                        end
                    endcase
                end
            end
        end else begin : g_single
            logic                 valid_q;
            logic [PAYLOAD_W-1:0] main_q;
            logic                 ready;

            assign ready       = !valid_q | out_ready_i;
            assign in_ready_o  = ready;
            assign out_valid_o = valid_q;
            assign out_data_o  = main_q;

            // A new load takes priority over emptying, giving full throughput.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (flush_i) begin
                    valid_q <= 1'b0;
                end else if (in_valid_i && ready) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data_i;
                end else if (valid_q && out_ready_i) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pipeline_reg_exe_mem_hs.sv
// EX->MEM pipeline register with valid/ready backpressure, flush, and
// saturating stall/bubble performance counters.
module pipeline_reg_exe_mem_hs
    import pipe_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID       = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     ALUOutE,
    input  logic [DATA_W-1:0]     WriteDataE,
    input  logic [REG_ADDR_W-1:0] WriteRegE,
    input  logic                  RegWriteE,
    input  logic                  MemtoRegE,
    input  logic                  MemWriteE,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     ALUOutM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [REG_ADDR_W-1:0] WriteRegM,
    output logic                  RegWriteM,
    output logic                  MemtoRegM,
    output logic                  MemWriteM,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt
);

    localparam int PAYLOAD_W = 2 * DATA_W + REG_ADDR_W + CTRL_W;

    ctrl_t                ctrlE;
    ctrl_t                ctrlM;
    logic [PAYLOAD_W-1:0] payloadE;
    logic [PAYLOAD_W-1:0] payloadM;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic [CNT_W-1:0]     bubble_q, bubble_d;

    assign ctrlE    = ctrl_t'{RegWriteE, MemtoRegE, MemWriteE};
    assign payloadE = {ALUOutE, WriteDataE, WriteRegE, ctrlE};

    pipe_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W),
        .SKID      (SKID)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (payloadE),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (payloadM)
    );

    assign {ALUOutM, WriteDataM, WriteRegM, ctrlM} = payloadM;

    // Stale control bits left behind by a flush or drain must never reach MEM.
    assign RegWriteM = out_valid & ctrlM.RegWrite;
    assign MemtoRegM = out_valid & ctrlM.MemtoReg;
    assign MemWriteM = out_valid & ctrlM.MemWrite;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (cnt_clr) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (out_valid && !out_ready && stall_q != '1) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (!out_valid && bubble_q != '1) begin
                bubble_d = bubble_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule
